vram_port_arbiter: RTL and testbench
====================================

// Module: vram_port_arbiter
// PURPOSE
//  Shares one synchronous VRAM port (17-bit word address, 16-bit data, 1-cycle registered read) between
//  NUM_REQ requesters (e.g. CPU bus, rasterizer, blitter). Round-robin grant, valid/ready request handshake,
//  pipelined one-access-per-cycle issue, per-requester read-response strobe. Sits between masters and one VRAM port.
// PARAMETERS
//  NUM_REQ     3       number of requesters (2..8)
//  ADDR_W      17      VRAM word-address width
//  DATA_W      16      VRAM data width (RGB565 pixel)
//  VRAM_WORDS  76800   valid words (320*240); addresses >= this are out of range
// PORTS
//  clk              in   1                 single clock; all logic on posedge clk
//  reset            in   1                 asynchronous, active-high reset
//  req_valid        in   NUM_REQ           request pending, one bit per requester
//  req_write        in   NUM_REQ           1 = write, 0 = read
//  req_addr         in   NUM_REQ*ADDR_W    word address, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata        in   NUM_REQ*DATA_W    write data, requester i at [i*DATA_W +: DATA_W]
//  req_ready        out  NUM_REQ           one-hot grant; request i accepted when valid[i]&ready[i]
//  rsp_valid        out  NUM_REQ           one-cycle strobe: read data for requester i on rsp_rdata
//  rsp_rdata        out  DATA_W            read data (shared bus, qualified by rsp_valid)
//  err_oob          out  1                 one-cycle pulse: accepted request had addr >= VRAM_WORDS
//  vram_address     out  ADDR_W            to VRAM address (registered)
//  vram_writeEnable out  1                 to VRAM writeEnable (registered)
//  vram_dataIn      out  DATA_W            to VRAM dataIn (registered)
//  vram_dataOut     in   DATA_W            from VRAM dataOut
// BEHAVIOUR
//  - Reset (async assert): req_ready=0, rsp_valid=0, err_oob=0, vram_address=0, vram_writeEnable=0,
//    vram_dataIn=0, rr pointer=0 (requester 0 highest priority). In-flight reads are dropped, no response.
//  - Arbitration, cycle C: req_ready = one-hot of first i with req_valid[i], searching from pointer upward,
//    wrapping mod NUM_REQ. req_ready is combinational from req_valid and pointer; req_ready=0 when no valid.
//    After a grant to i, pointer <= (i+1) mod NUM_REQ; with no grant, pointer holds.
//  - Masters hold req_valid/addr/wdata/write stable until accepted; req_valid must not depend on req_ready.
//  - Issue: accepted request registered at end of C and driven on vram_* during C+1.
//    Write: vram_writeEnable=1, vram_dataIn=wdata. Read: vram_writeEnable=0.
//  - Read response: VRAM samples at end of C+1; in C+2 rsp_valid[i]=1, rsp_rdata=vram_dataOut.
//    Fixed latency 2 cycles accept->response; fully pipelined, one response per cycle max.
//  - Writes produce no response. Write then read same address in consecutive cycles returns new data.
//  - Idle cycle (no grant): vram_writeEnable=0, vram_address/vram_dataIn hold last value; no rsp_valid.
//  - Out of range (addr >= VRAM_WORDS): still accepted; err_oob=1 in C+1; VRAM not written
//    (vram_writeEnable=0, vram_address holds). Read: rsp_valid[i]=1 in C+2 with rsp_rdata=0.
//  - rsp_rdata = 0 when no rsp_valid bit set.
//  - Pipeline carries {valid, requester index, is_read, oob} two stages; no backpressure on responses.
// STRUCTURE
//  - Package vram_pkg: VRAM_H_RES=320, VRAM_V_RES=240, VRAM_WORDS, VRAM_ADDR_W=17, VRAM_DATA_W=16,
//    typedef/struct of pipeline tag {valid, idx, is_read, oob}.
//  - Sub-module rr_arbiter #(N): req[N] -> one-hot gnt[N], owns rotating pointer (async reset to 0),
//    advances on any grant. Remainder (issue regs, tag pipe, response mux) lives in this module.
// TESTING (bench models VRAM as 76800x16, write-priority, 1-cycle registered read)
//  1. Reset, then req1 read addr 0x00010 (model=0xBEEF) -> req_ready[1] same cycle, vram_address=0x00010
//     next cycle, rsp_valid=3'b010, rsp_rdata=0xBEEF two cycles after accept.
//  2. All three reads held continuously from reset -> grant order 0,1,2,0,1,2; each rsp_valid strobe 2 cycles
//     after its accept; one VRAM access every cycle.
//  3. req2 write 0x1234 to 0x12BFF, next cycle req0 read 0x12BFF -> vram_writeEnable=1 one cycle,
//     then rsp_valid[0] with 0x1234.
//  4. req0 write 0x12C00 -> err_oob pulse, vram_writeEnable stays 0, model unchanged;
//     req0 read 0x12C00 -> err_oob pulse, rsp_valid[0] with 0x0000.
//  5. Accept read on req2, assert reset next cycle -> no rsp_valid, all outputs 0 immediately;
//     after release with req0 and req2 valid -> req0 granted first.
//  6. req0 alone reads 0..15 back-to-back -> 16 consecutive rsp_valid[0] strobes, data in address order.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared constants and pipeline tag type for the VRAM port arbiter.
// The frame buffer is 320x240 RGB565 words on a single synchronous port.
package vram_pkg;

  localparam int VRAM_H_RES  = 320;
  localparam int VRAM_V_RES  = 240;
  localparam int VRAM_WORDS  = VRAM_H_RES * VRAM_V_RES;
  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 16;

  // idx is 3 bits wide so up to 8 requesters fit.
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic       is_read;
    logic       oob;
  } vram_tag_t;

endpackage

// File: rtl/vram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// The pointer moves just past the winner so every requester gets a turn.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             any;

  // Pick the first pending request at or above ptr, wrapping around.
  always_comb begin
    gnt     = '0;
    any     = 1'b0;
    ptr_nxt = ptr;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        gnt[j]  = 1'b1;
        any     = 1'b1;
        ptr_nxt = (j + 1 == N) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  // Advance the pointer only when someone was granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares one VRAM port between NUM_REQ masters, one access per cycle.
// Reads return two cycles after accept on a shared, strobe-qualified bus.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int VRAM_WORDS = vram_pkg::VRAM_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      err_oob,
  output logic [ADDR_W-1:0]         vram_address,
  output logic                      vram_writeEnable,
  output logic [DATA_W-1:0]         vram_dataIn,
  input  logic [DATA_W-1:0]         vram_dataOut
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(VRAM_WORDS);

  logic [NUM_REQ-1:0] gnt;
  logic               accept;
  logic [2:0]         sel_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_write;
  logic               sel_oob;
  vram_tag_t          tag1;
  vram_tag_t          tag2;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign req_ready = reset ? '0 : gnt;
  assign accept    = |req_ready;
  assign sel_oob   = {1'b0, sel_addr} >= LIMIT;
  assign err_oob   = tag1.valid & tag1.oob;

  // Route the granted requester's command to the issue stage.
  always_comb begin
    sel_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_idx   = 3'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  // Issue stage: out-of-range or idle cycles leave address/data untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_address     <= '0;
      vram_writeEnable <= 1'b0;
      vram_dataIn      <= '0;
      tag1             <= '0;
    end else begin
      vram_writeEnable <= accept & sel_write & ~sel_oob;
      if (accept && !sel_oob) begin
        vram_address <= sel_addr;
        if (sel_write) vram_dataIn <= sel_wdata;
      end
      tag1.valid   <= accept;
      tag1.idx     <= sel_idx;
      tag1.is_read <= ~sel_write;
      tag1.oob     <= sel_oob;
    end
  end

  // Second tag stage lines up with VRAM's registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag2 <= '0;
    end else begin
      tag2 <= tag1;
    end
  end

  // Steer read data to its requester; out-of-range reads return zero.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (tag2.valid && tag2.is_read) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag2.idx == 3'(i)) rsp_valid[i] = 1'b1;
      end
      if (!tag2.oob) rsp_rdata = vram_dataOut;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: VRAM model plus arbiter/memory reference.
// Read responses are scoreboarded with the cycle they are due.
module tb_vram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int WORDS = 76800;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            err_oob;
  logic [AW-1:0]   vram_address;
  logic            vram_writeEnable;
  logic [DW-1:0]   vram_dataIn;
  logic [DW-1:0]   vram_dataOut;

  logic [N-1:0]  rv;
  logic [N-1:0]  rw;
  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];

  logic [DW-1:0] mem     [WORDS];
  logic [DW-1:0] ref_mem [WORDS];

  typedef struct {
    int          due;
    logic [2:0]  mask;
    logic [15:0] data;
  } exp_t;

  exp_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ptr      = 0;

  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_din;
  logic          e_err;

  vram_port_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .err_oob          (err_oob),
    .vram_address     (vram_address),
    .vram_writeEnable (vram_writeEnable),
    .vram_dataIn      (vram_dataIn),
    .vram_dataOut     (vram_dataOut)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = rv;
    req_write = rw;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = ra[i];
      req_wdata[i*DW +: DW] = rd[i];
    end
  end

  always @(posedge clk) begin
    if (int'(vram_address) < WORDS) begin
      if (vram_writeEnable) mem[vram_address] <= vram_dataIn;
      vram_dataOut <= vram_writeEnable ? vram_dataIn
                                       : mem[vram_address];
    end else begin
      vram_dataOut <= '0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rdata", 32'(rsp_rdata), 32'h0);
      check("rst_err", 32'(err_oob), 32'h0);
      check("rst_addr", 32'(vram_address), 32'h0);
      check("rst_we", 32'(vram_writeEnable), 32'h0);
      check("rst_din", 32'(vram_dataIn), 32'h0);
      ptr = 0;
      sb.delete();
      e_addr = '0;
      e_we   = 1'b0;
      e_din  = '0;
      e_err  = 1'b0;
    end else begin
      int   g;
      logic oob;
      logic [2:0] m;
      check("vram_addr", 32'(vram_address), 32'(e_addr));
      check("vram_we", 32'(vram_writeEnable), 32'(e_we));
      check("vram_din", 32'(vram_dataIn), 32'(e_din));
      check("err_oob", 32'(err_oob), 32'(e_err));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t r;
        r = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(r.mask));
        check("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
      end else begin
        check("rsp_idle", 32'(rsp_valid), 32'h0);
        check("rsp_idle_data", 32'(rsp_rdata), 32'h0);
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (g < 0 && rv[j]) g = j;
      end
      m = (g < 0) ? 3'b000 : 3'(1 << g);
      check("req_ready", 32'(req_ready), 32'(m));
      e_we  = 1'b0;
      e_err = 1'b0;
      if (g >= 0) begin
        oob   = int'(ra[g]) >= WORDS;
        e_err = oob;
        e_we  = rw[g] & ~oob;
        if (!oob) begin
          e_addr = ra[g];
          if (rw[g]) begin
            e_din = rd[g];
            ref_mem[ra[g]] = rd[g];
          end
        end
        if (!rw[g]) begin
          exp_t e;
          e.due  = cyc + 2;
          e.mask = m;
          e.data = oob ? 16'h0 : ref_mem[ra[g]];
          sb.push_back(e);
        end
        ptr = (g + 1) % N;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = 16'(i * 7 + 3) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 7 + 3) ^ 16'h5A5A;
    end
    mem[16'h10]     = 16'hBEEF;
    ref_mem[16'h10] = 16'hBEEF;
    reset = 1'b1;
    rv = '0;
    rw = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rd[i] = '0;
    end
    step(2);
    reset = 1'b0;
    step(1);

    // single read from requester 1
    rv[1] = 1'b1;
    ra[1] = 17'h00010;
    step(1);
    rv = '0;
    step(4);

    // all three reading continuously from reset
    reset = 1'b1;
    rv = 3'b111;
    ra[0] = 17'h00100;
    ra[1] = 17'h00200;
    ra[2] = 17'h00300;
    step(2);
    reset = 1'b0;
    step(6);
    rv = '0;
    step(4);

    // write then read same address, last in-range word
    rv = 3'b100;
    rw[2] = 1'b1;
    ra[2] = 17'h12BFF;
    rd[2] = 16'h1234;
    step(1);
    rv = 3'b001;
    rw[0] = 1'b0;
    ra[0] = 17'h12BFF;
    step(1);
    rv = '0;
    rw = '0;
    step(4);

    // first out-of-range address, write then read
    rv = 3'b001;
    rw[0] = 1'b1;
    ra[0] = 17'h12C00;
    rd[0] = 16'hABCD;
    step(1);
    rw[0] = 1'b0;
    step(1);
    rv = '0;
    step(4);
    check("oob_no_clobber", 32'(mem[17'h12BFF]), 32'h1234);

    // reset while a read is in flight
    rv = 3'b100;
    ra[2] = 17'h00020;
    step(1);
    rv = '0;
    reset = 1'b1;
    #1;
    check("async_rst_addr", 32'(vram_address), 32'h0);
    check("async_rst_din", 32'(vram_dataIn), 32'h0);
    step(2);
    reset = 1'b0;
    rv = 3'b101;
    ra[0] = 17'h00030;
    ra[2] = 17'h00040;
    step(2);
    rv = '0;
    step(4);

    // back-to-back streaming reads on requester 0
    rv = 3'b001;
    for (int a = 0; a < 16; a++) begin
      ra[0] = 17'(a);
      step(1);
    end
    rv = '0;
    step(4);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
